// File: rtl/riscv_pkg.sv
// riscv_pkg: encodings shared by the hazard unit and its mul/div stall FSM.
package riscv_pkg;

  // ALU operand mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Mul/div stall FSM states
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;

  // R-type opcode with the M-extension funct7 marks a mul/div instruction
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  function automatic logic is_muldiv(input logic [6:0] op, input logic [6:0] funct7);
    return (op == OP_RTYPE) && (funct7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/md_stall_fsm.sv
// md_stall_fsm: holds a mul/div in EX for MD_LATENCY cycles.
// The start cycle (still in RUN) already stalls, so the instruction occupies
// EX for one start cycle plus MD_LATENCY-1 wait cycles; the final wait cycle
// (counter==1) releases the pipeline and pulses md_done.
module md_stall_fsm
  import riscv_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_e,
  input  logic [6:0] funct7_e,
  output logic       md_stall,
  output logic       md_busy,
  output logic       md_done
);

  logic [0:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       md_start;

  // Next-state, counter and output decode; outputs forced quiet during reset
  always_comb begin
    md_start = is_muldiv(op_e, funct7_e);
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (md_start) begin
          state_d  = ST_MD_WAIT;
          cnt_d    = 6'(MD_LATENCY - 1);
          md_stall = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        md_busy = 1'b1;
        cnt_d   = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          md_done = 1'b1;
          state_d = ST_RUN;
        end else begin
          md_stall = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 6'd0;
      end
    endcase
    if (reset) begin
      md_stall = 1'b0;
      md_busy  = 1'b0;
      md_done  = 1'b0;
    end
  end

  // State and counter registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, RAW/load-use stalls, branch flushes, mul/div stall
// and a free-running stall-cycle counter for the 5-stage pipeline.
// Build option HAZARD_FWD_EN: when defined, operands are forwarded from
// MEM/WB and only load-use stalls; when undefined, forwarding is off and any
// RAW dependency on EX/MEM/WB stalls decode instead.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [6:0]  OpE,
  input  logic [6:0]  Funct7E,
  input  logic        RegWriteE,
  input  logic        LoadE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdBusy,
  output logic        MdDone,
  output logic [31:0] StallCount
);

  logic [1:0]  fwd_a, fwd_b;
  logic        haz_stall;
  logic        md_stall, md_busy, md_done, md_hold;
  logic [31:0] stall_count_q, stall_count_d;

  md_stall_fsm #(.MD_LATENCY(MD_LATENCY)) u_md_fsm (
    .clk      (clk),
    .reset    (reset),
    .op_e     (OpE),
    .funct7_e (Funct7E),
    .md_stall (md_stall),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

`ifdef HAZARD_FWD_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = RegWriteE;

  // MEM beats WB for forwarding; only loads force a decode stall
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (Rs1E == RdM))      fwd_a = FWD_MEM;
    else if (RegWriteW && (RdW != 5'd0) && (Rs1E == RdW)) fwd_a = FWD_WB;
    if (RegWriteM && (RdM != 5'd0) && (Rs2E == RdM))      fwd_b = FWD_MEM;
    else if (RegWriteW && (RdW != 5'd0) && (Rs2E == RdW)) fwd_b = FWD_WB;
    haz_stall = LoadE && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{Rs1E, Rs2E, LoadE};

  // No bypass paths: decode waits until every in-flight writer has retired
  always_comb begin
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    haz_stall = ((Rs1D != 5'd0) &&
                 ((RegWriteE && (Rs1D == RdE)) ||
                  (RegWriteM && (Rs1D == RdM)) ||
                  (RegWriteW && (Rs1D == RdW)))) ||
                ((Rs2D != 5'd0) &&
                 ((RegWriteE && (Rs2D == RdE)) ||
                  (RegWriteM && (Rs2D == RdM)) ||
                  (RegWriteW && (Rs2D == RdW))));
  end
`endif

  assign md_hold = md_busy || md_stall;

  // Stall/flush arbitration: an active mul/div overrides hazards and branches
  always_comb begin
    ForwardAE = reset ? FWD_RF : fwd_a;
    ForwardBE = reset ? FWD_RF : fwd_b;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    MdBusy    = md_busy;
    MdDone    = md_done;
    if (md_hold) begin
      StallF = md_stall;
      StallD = md_stall;
      StallE = md_stall;
      FlushM = md_stall;
    end else begin
      if (haz_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
    end
    if (reset) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      MdBusy = 1'b0;
      MdDone = 1'b0;
    end
  end

  // Count fetch-stall cycles; the 32-bit add wraps naturally
  always_comb begin
    stall_count_d = stall_count_q + {31'd0, StallF};
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= 32'd0;
    else       stall_count_q <= stall_count_d;
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl built with MD_LATENCY=4.
// Follows the HAZARD_FWD_EN build option for forwarding/RAW expectations.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // flag byte order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone}
  localparam logic [7:0] F_NONE    = 8'b0000_0000;
  localparam logic [7:0] F_LWSTALL = 8'b1100_1000;
  localparam logic [7:0] F_BRANCH  = 8'b0001_1000;
  localparam logic [7:0] F_BOTH    = 8'b1101_1000;
  localparam logic [7:0] F_MDSTART = 8'b1110_0100;
  localparam logic [7:0] F_MDWAIT  = 8'b1110_0110;
  localparam logic [7:0] F_MDDONE  = 8'b0000_0011;

  logic        clk, reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [6:0]  OpE, Funct7E;
  logic        RegWriteE, LoadE, PCSrcE, RegWriteM, RegWriteW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone;
  logic [31:0] StallCount;
  logic [11:0] obs_ctl;

  typedef struct {
    logic [11:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_cnt;
  int          n_checks;
  int          n_fail;

  hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .OpE(OpE), .Funct7E(Funct7E), .RegWriteE(RegWriteE), .LoadE(LoadE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdBusy(MdBusy), .MdDone(MdDone), .StallCount(StallCount)
  );

  assign obs_ctl = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone};

  // free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] fl);
    return {fa, fb, fl};
  endfunction

  task automatic apply_idle();
    reset = 1'b0;
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    OpE = 7'd0; Funct7E = 7'd0;
    RegWriteE = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  task automatic apply_mul();
    OpE = 7'b0110011; Funct7E = 7'b0000001; RegWriteE = 1'b1; RdE = 5'd10;
  endtask

  // record expectation for the current cycle and advance the counter model
  task automatic push_exp(input logic [11:0] ctl);
    exp_t e;
    e.ctl = ctl;
    e.cnt = model_cnt;
    exp_q.push_back(e);
    if (reset) model_cnt = 32'd0;
    else       model_cnt = model_cnt + {31'd0, ctl[7]};
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply_idle();
      reset = 1'b1;
      LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
      RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
      OpE = 7'b0110011; Funct7E = 7'b0000001;
      push_exp(mk(2'b00, 2'b00, F_NONE));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("[TB] FAIL reset_ctl cycle %0d: got %b, expected %b", i, obs_ctl, e.ctl); end
      n_checks++;
      if (StallCount !== e.cnt) begin n_fail++; $display("[TB] FAIL reset_count cycle %0d: got %0d, expected %0d", i, StallCount, e.cnt); end
    end
  endtask

  task automatic test_forwarding();
    exp_t e;
    logic [4:0] r1e [6] = '{5'd5, 5'd5, 5'd3, 5'd0, 5'd6, 5'd8};
    logic [4:0] r2e [6] = '{5'd0, 5'd5, 5'd4, 5'd0, 5'd7, 5'd8};
    logic [4:0] rdm [6] = '{5'd5, 5'd5, 5'd4, 5'd0, 5'd6, 5'd8};
    logic       rwm [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] rdw [6] = '{5'd5, 5'd5, 5'd3, 5'd0, 5'd7, 5'd9};
    logic       rww [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] efa [6] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    logic [1:0] efb [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply_idle();
      Rs1E = r1e[i]; Rs2E = r2e[i]; RdM = rdm[i]; RegWriteM = rwm[i]; RdW = rdw[i]; RegWriteW = rww[i];
      push_exp(FWD ? mk(efa[i], efb[i], F_NONE) : mk(2'b00, 2'b00, F_NONE));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("[TB] FAIL fwd_ctl row %0d: got %b, expected %b", i, obs_ctl, e.ctl); end
      n_checks++;
      if (StallCount !== e.cnt) begin n_fail++; $display("[TB] FAIL fwd_count row %0d: got %0d, expected %0d", i, StallCount, e.cnt); end
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    logic [11:0] ex;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      apply_idle();
      ex = mk(2'b00, 2'b00, F_NONE);
      case (i)
        0: begin LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; ex = mk(2'b00, 2'b00, F_LWSTALL); end
        2: begin LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd0; end
        3: begin LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1; ex = mk(2'b00, 2'b00, F_BOTH); end
        5: begin LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs1D = 5'd8; Rs2D = 5'd9; end
        6: begin PCSrcE = 1'b1; ex = mk(2'b00, 2'b00, F_BRANCH); end
        default: ;
      endcase
      push_exp(ex);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("[TB] FAIL stall_ctl row %0d: got %b, expected %b", i, obs_ctl, e.ctl); end
      n_checks++;
      if (StallCount !== e.cnt) begin n_fail++; $display("[TB] FAIL stall_count row %0d: got %0d, expected %0d", i, StallCount, e.cnt); end
    end
  endtask

  task automatic test_raw_stall();
    exp_t e;
    logic [11:0] ex;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      apply_idle();
      ex = mk(2'b00, 2'b00, F_NONE);
      case (i)
        0: begin RegWriteM = 1'b1; RdM = 5'd3; Rs1D = 5'd3; Rs1E = 5'd3;
                 ex = FWD ? mk(2'b10, 2'b00, F_NONE) : mk(2'b00, 2'b00, F_LWSTALL); end
        1: begin RegWriteW = 1'b1; RdW = 5'd12; Rs2D = 5'd12;
                 ex = FWD ? mk(2'b00, 2'b00, F_NONE) : mk(2'b00, 2'b00, F_LWSTALL); end
        2: begin RdM = 5'd3; Rs1D = 5'd3; end
        3: begin RegWriteE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
                 ex = FWD ? mk(2'b00, 2'b00, F_NONE) : mk(2'b00, 2'b00, F_LWSTALL); end
        default: begin RegWriteW = 1'b1; RdW = 5'd0; end
      endcase
      push_exp(ex);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("[TB] FAIL raw_ctl row %0d: got %b, expected %b", i, obs_ctl, e.ctl); end
      n_checks++;
      if (StallCount !== e.cnt) begin n_fail++; $display("[TB] FAIL raw_count row %0d: got %0d, expected %0d", i, StallCount, e.cnt); end
    end
  endtask

  task automatic test_muldiv();
    exp_t e;
    logic [11:0] ex;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      apply_idle();
      ex = mk(2'b00, 2'b00, F_NONE);
      case (i)
        0: begin OpE = 7'b0110011; Funct7E = 7'b0000000; RegWriteE = 1'b1; RdE = 5'd10; end
        1: begin apply_mul(); ex = mk(2'b00, 2'b00, F_MDSTART); end
        2: begin apply_mul(); PCSrcE = 1'b1; ex = mk(2'b00, 2'b00, F_MDWAIT); end
        3: begin apply_mul(); LoadE = 1'b1; Rs1D = 5'd10; ex = mk(2'b00, 2'b00, F_MDWAIT); end
        4: begin apply_mul(); ex = mk(2'b00, 2'b00, F_MDDONE); end
        5: begin PCSrcE = 1'b1; ex = mk(2'b00, 2'b00, F_BRANCH); end
        default: ;
      endcase
      push_exp(ex);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("[TB] FAIL md_ctl row %0d: got %b, expected %b", i, obs_ctl, e.ctl); end
      n_checks++;
      if (StallCount !== e.cnt) begin n_fail++; $display("[TB] FAIL md_count row %0d: got %0d, expected %0d", i, StallCount, e.cnt); end
    end
  endtask

  task automatic test_md_reset();
    exp_t e;
    logic [11:0] ex;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      apply_idle();
      ex = mk(2'b00, 2'b00, F_NONE);
      case (i)
        0: begin apply_mul(); ex = mk(2'b00, 2'b00, F_MDSTART); end
        1: begin apply_mul(); ex = mk(2'b00, 2'b00, F_MDWAIT); end
        2: begin apply_mul(); reset = 1'b1; end
        default: ;
      endcase
      push_exp(ex);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("[TB] FAIL mdrst_ctl row %0d: got %b, expected %b", i, obs_ctl, e.ctl); end
      n_checks++;
      if (StallCount !== e.cnt) begin n_fail++; $display("[TB] FAIL mdrst_count row %0d: got %0d, expected %0d", i, StallCount, e.cnt); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [11:0] ex;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      apply_idle();
      ex = mk(2'b00, 2'b00, F_NONE);
      case (i)
        0, 4: begin apply_mul(); ex = mk(2'b00, 2'b00, F_MDSTART); end
        1, 2, 5, 6: begin apply_mul(); ex = mk(2'b00, 2'b00, F_MDWAIT); end
        3, 7: begin apply_mul(); ex = mk(2'b00, 2'b00, F_MDDONE); end
        8: begin LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; ex = mk(2'b00, 2'b00, F_LWSTALL); end
        default: ;
      endcase
      push_exp(ex);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_ctl !== e.ctl) begin n_fail++; $display("[TB] FAIL b2b_ctl row %0d: got %b, expected %b", i, obs_ctl, e.ctl); end
      n_checks++;
      if (StallCount !== e.cnt) begin n_fail++; $display("[TB] FAIL b2b_count row %0d: got %0d, expected %0d", i, StallCount, e.cnt); end
    end
  endtask

  // test sequence
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_cnt = 32'd0;
    apply_idle();
    reset = 1'b1;
    $display("[TB] hazard_ctrl bench, forwarding build = %0d", FWD);
    test_reset();
    test_forwarding();
    test_stall_flush();
    test_raw_stall();
    test_muldiv();
    test_md_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
